hilo_muldiv_ctrl: RTL and testbench

HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

---
 rtl/hilo_muldiv_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Owns the architectural HI/LO registers and sequences MULT/MULTU/DIV/DIVU
//   through an external fixed-latency multiplier and an external handshaked
//   divider. MTHI/MTLO write HI/LO directly. MFHI/MFLO are never accepted
//   here; they only stall while an operation is in flight.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   en_EX, op_EX                   EX instruction valid / opcode (0..7)
//   rs_data_EX, rt_data_EX         forwarded operands
//   flush                          kills the EX op and any in-flight op
//   stall_EX                       hold EX while an op is in flight
//   mul_start/mul_signed/mul_a/b   multiplier request (start is one pulse)
//   mul_result                     product, valid MUL_LAT cycles after start
//   div_valid/div_ready            divider request handshake
//   div_signed/div_dividend/div_divisor  divider request payload
//   div_out_valid, div_quotient, div_remainder  divider result strobe
//   hi, lo                         architectural HI/LO
module hilo_muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_EX,
    input  logic [2:0]  op_EX,
    input  logic [31:0] rs_data_EX,
    input  logic [31:0] rt_data_EX,
    input  logic        flush,
    output logic        stall_EX,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_valid,
    input  logic        div_ready,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_out_valid,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [2:0] {
        IDLE, MUL_WAIT, DIV_ISSUE, DIV_WAIT, DIV_DRAIN
    } state_t;

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_d;
        logic [31:0] lo_d;
    } hilo_wr_t;

    state_t   state_q, state_d;
    logic [3:0] cnt_q;
    logic     accept;
    logic     mul_go, div_go;
    hilo_wr_t wr;

    assign stall_EX  = en_EX & (op_EX != 3'd0) & (state_q != IDLE);
    assign accept    = en_EX & ~flush & ~stall_EX &
                       (op_EX >= OP_MULT) & (op_EX <= OP_MTLO);
    // Request is a pure function of state, so a flush in DIV_ISSUE still
    // presents valid that cycle and a coincident ready completes the handshake.
    assign div_valid = (state_q == DIV_ISSUE);

    always_comb begin
        state_d  = state_q;
        mul_go   = 1'b0;
        div_go   = 1'b0;
        wr       = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op_EX)
                        OP_MULT, OP_MULTU: begin
                            mul_go  = 1'b1;
                            state_d = MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero is architecturally a no-op.
                            if (rt_data_EX != 32'd0) begin
                                div_go  = 1'b1;
                                state_d = DIV_ISSUE;
                            end
                        end
                        OP_MTHI: begin
                            wr.hi_we = 1'b1;
                            wr.hi_d  = rs_data_EX;
                        end
                        OP_MTLO: begin
                            wr.lo_we = 1'b1;
                            wr.lo_d  = rs_data_EX;
                        end
                        default: ;
                    endcase
                end
            end
            MUL_WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    wr.hi_we = 1'b1;
                    wr.lo_we = 1'b1;
                    wr.hi_d  = mul_result[63:32];
                    wr.lo_d  = mul_result[31:0];
                    state_d  = IDLE;
                end
            end
            DIV_ISSUE: begin
                if (div_ready)  state_d = flush ? DIV_DRAIN : DIV_WAIT;
                else if (flush) state_d = IDLE;
            end
            DIV_WAIT: begin
                if (flush) begin
                    // A strobe in the flush cycle is the divider's last word;
                    // nothing remains to drain.
                    state_d = div_out_valid ? IDLE : DIV_DRAIN;
                end else if (div_out_valid) begin
                    wr.hi_we = 1'b1;
                    wr.lo_we = 1'b1;
                    wr.hi_d  = div_remainder;
                    wr.lo_d  = div_quotient;
                    state_d  = IDLE;
                end
            end
            DIV_DRAIN: begin
                if (div_out_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            mul_start    <= 1'b0;
            mul_signed   <= 1'b0;
            mul_a        <= 32'd0;
            mul_b        <= 32'd0;
            div_signed   <= 1'b0;
            div_dividend <= 32'd0;
            div_divisor  <= 32'd0;
            hi           <= 32'd0;
            lo           <= 32'd0;
        end else begin
            state_q   <= state_d;
            mul_start <= mul_go;
            if (mul_go) begin
                mul_a      <= rs_data_EX;
                mul_b      <= rt_data_EX;
                mul_signed <= (op_EX == OP_MULT);
                cnt_q      <= 4'(MUL_LAT);
            end else if (state_q == MUL_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (div_go) begin
                div_dividend <= rs_data_EX;
                div_divisor  <= rt_data_EX;
                div_signed   <= (op_EX == OP_DIV);
            end
            if (wr.hi_we) hi <= wr.hi_d;
            if (wr.lo_we) lo <= wr.lo_d;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_EX;
    logic [2:0]  op_EX;
    logic [31:0] rs_data_EX, rt_data_EX;
    logic        flush;
    logic        stall_EX, mul_start, mul_signed;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_result;
    logic        div_valid, div_ready, div_signed;
    logic [31:0] div_dividend, div_divisor;
    logic        div_out_valid;
    logic [31:0] div_quotient, div_remainder;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk(clk), .reset(reset), .en_EX(en_EX), .op_EX(op_EX),
        .rs_data_EX(rs_data_EX), .rt_data_EX(rt_data_EX), .flush(flush),
        .stall_EX(stall_EX), .mul_start(mul_start), .mul_signed(mul_signed),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .div_valid(div_valid), .div_ready(div_ready), .div_signed(div_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_out_valid(div_out_valid), .div_quotient(div_quotient),
        .div_remainder(div_remainder), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs settle 1 time unit after an edge; checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic en, input logic [2:0] op,
                      input logic [31:0] rs, input logic [31:0] rt);
        en_EX = en; op_EX = op; rs_data_EX = rs; rt_data_EX = rt;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; mul_result = '0;
        div_ready = 1'b0; div_out_valid = 1'b0; div_quotient = '0; div_remainder = '0;
        ex(1'b0, 3'd0, '0, '0);
        tick(); tick();
        reset = 1'b0;
        #2;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_div_valid", div_valid, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_stall", stall_EX, 0);

        // MULT -3 x 5, MFHI behind it
        ex(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5);
        #2 chk("mult_accept_stall", stall_EX, 0);
        tick();                                  // T+1
        ex(1'b1, 3'd7, '0, '0);
        #2;
        chk("mult_start_T1", mul_start, 1);
        chk("mult_signed", mul_signed, 1);
        chk("mult_a", mul_a, 32'hFFFF_FFFD);
        chk("mult_b", mul_b, 32'd5);
        chk("mfhi_stall_T1", stall_EX, 1);
        tick();                                  // T+2
        #2;
        chk("mult_start_T2", mul_start, 0);
        chk("mfhi_stall_T2", stall_EX, 1);
        tick();                                  // T+3: product valid
        mul_result = 64'hFFFF_FFFF_FFFF_FFF1;
        #2 chk("mfhi_stall_T3", stall_EX, 1);
        chk("mult_hi_early", hi, 0);
        tick();                                  // T+4
        mul_result = '0;
        #2;
        chk("mfhi_stall_T4", stall_EX, 0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        ex(1'b0, 3'd0, '0, '0);

        // DIVU 17/5, ready after 3 cycles, result 4 cycles later
        tick();
        ex(1'b1, 3'd4, 32'd17, 32'd5);
        tick();
        ex(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("divu_valid_held", div_valid, 1);
            chk("divu_dividend", div_dividend, 32'd17);
            chk("divu_divisor", div_divisor, 32'd5);
            chk("divu_signed", div_signed, 0);
            tick();
        end
        div_ready = 1'b1;
        tick();
        div_ready = 1'b0;
        ex(1'b1, 3'd1, 32'd1, 32'd1);            // following MULT
        #2 chk("divu_valid_drop", div_valid, 0);
        for (int i = 0; i < 3; i++) begin
            chk("divu_mult_stall", stall_EX, 1);
            tick();
        end
        div_out_valid = 1'b1; div_quotient = 32'd3; div_remainder = 32'd2;
        #2 chk("divu_mult_stall_wr", stall_EX, 1);
        tick();
        div_out_valid = 1'b0;
        #2;
        chk("divu_mult_nostall", stall_EX, 0);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd2);
        ex(1'b0, 3'd0, '0, '0);

        // DIV 7/0 is a no-op; MTHI right after
        tick();
        ex(1'b1, 3'd3, 32'd7, 32'd0);
        tick();
        ex(1'b1, 3'd5, 32'h0000_AAAA, '0);
        #2;
        chk("div0_valid", div_valid, 0);
        chk("div0_hi", hi, 32'd2);
        chk("div0_lo", lo, 32'd3);
        chk("div0_next_stall", stall_EX, 0);
        tick();
        ex(1'b0, 3'd0, '0, '0);
        #2 chk("mthi_hi", hi, 32'h0000_AAAA);

        // DIV -7/2, flush in DIV_WAIT, then drain
        tick();
        ex(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
        tick();
        ex(1'b0, 3'd0, '0, '0);
        #2 chk("div_signed", div_signed, 1);
        div_ready = 1'b1;
        tick();
        div_ready = 1'b0;
        flush = 1'b1;
        tick();                                  // DIV_DRAIN
        flush = 1'b0;
        ex(1'b1, 3'd7, '0, '0);
        #2 chk("drain_stall", stall_EX, 1);
        div_out_valid = 1'b1; div_quotient = 32'd99; div_remainder = 32'd77;
        tick();
        div_out_valid = 1'b0;
        #2;
        chk("drain_idle", stall_EX, 0);
        chk("drain_hi", hi, 32'h0000_AAAA);
        chk("drain_lo", lo, 32'd3);
        ex(1'b0, 3'd0, '0, '0);

        // MULT 2x3 with MTLO stalled behind it
        tick();
        ex(1'b1, 3'd1, 32'd2, 32'd3);
        tick();                                  // T+1
        ex(1'b1, 3'd6, 32'h0000_1234, '0);
        #2 chk("mtlo_stall_T1", stall_EX, 1);
        tick(); tick();                          // T+3
        mul_result = 64'd6;
        #2 chk("mtlo_stall_T3", stall_EX, 1);
        tick();                                  // T+4
        mul_result = '0;
        #2;
        chk("mtlo_nostall", stall_EX, 0);
        chk("mul6_lo", lo, 32'd6);
        chk("mul6_hi", hi, 32'd0);
        tick();
        ex(1'b0, 3'd0, '0, '0);
        #2 chk("mtlo_lo", lo, 32'h0000_1234);

        // MULTU flushed in MUL_WAIT; late product ignored
        ex(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2);
        tick();
        ex(1'b0, 3'd0, '0, '0);
        #2 chk("multu_signed", mul_signed, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mul_result = 64'h1_FFFF_FFFE;
        ex(1'b1, 3'd7, '0, '0);
        #2 chk("mulflush_idle", stall_EX, 0);
        ex(1'b0, 3'd0, '0, '0);
        tick();
        mul_result = '0;
        #2;
        chk("mulflush_hi", hi, 32'd0);
        chk("mulflush_lo", lo, 32'h0000_1234);

        // flush in IDLE blocks MTHI
        ex(1'b1, 3'd5, 32'hDEAD_BEEF, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ex(1'b0, 3'd0, '0, '0);
        #2 chk("idleflush_hi", hi, 32'd0);

        // flush in DIV_ISSUE without ready
        ex(1'b1, 3'd4, 32'd9, 32'd4);
        tick();
        ex(1'b0, 3'd0, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ex(1'b1, 3'd7, '0, '0);
        #2;
        chk("issueflush_valid", div_valid, 0);
        chk("issueflush_idle", stall_EX, 0);
        ex(1'b0, 3'd0, '0, '0);

        // reset during DIV_ISSUE
        ex(1'b1, 3'd3, 32'd10, 32'd3);
        tick();
        ex(1'b0, 3'd0, '0, '0);
        #2 chk("rstdiv_valid_pre", div_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ex(1'b1, 3'd7, '0, '0);
        #2;
        chk("rstdiv_valid", div_valid, 0);
        chk("rstdiv_idle", stall_EX, 0);
        chk("rstdiv_hi", hi, 0);
        chk("rstdiv_lo", lo, 0);
        chk("rstdiv_dividend", div_dividend, 0);
        ex(1'b0, 3'd0, '0, '0);

        // flush coincident with result strobe in DIV_WAIT
        ex(1'b1, 3'd4, 32'd8, 32'd3);
        tick();
        ex(1'b0, 3'd0, '0, '0);
        div_ready = 1'b1;
        tick();
        div_ready = 1'b0;
        flush = 1'b1; div_out_valid = 1'b1; div_quotient = 32'd5; div_remainder = 32'd5;
        tick();
        flush = 1'b0; div_out_valid = 1'b0;
        ex(1'b1, 3'd7, '0, '0);
        #2;
        chk("flushwin_idle", stall_EX, 0);
        chk("flushwin_hi", hi, 0);
        chk("flushwin_lo", lo, 0);
        ex(1'b0, 3'd0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
